// File: rtl/adder_activity_pkg.sv
// Shared definitions for the adder activity monitor: FSM encoding,
// popcount width helper and saturating-add width rules.
package adder_activity_pkg;

  // Measurement window FSM encoding.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_COUNT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Saturating adds are evaluated one bit wider than the accumulator;
  // the extra top bit is the carry-out that signals saturation.
  localparam int SAT_GUARD_W = 1;

  // tog_total is two bits wider than a per-bus counter so it can hold
  // the sum of all three buses before saturating.
  localparam int TOT_EXTRA_W = 2;

  // Number of bits needed to hold a population count of an n-bit vector.
  function automatic int pc_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/adder_activity_monitor_popcount.sv
// Combinational population count of a W-bit vector.
module popcount
  import adder_activity_pkg::*;
#(
  parameter int W = 7
) (
  input  logic [W-1:0]             vec,
  output logic [pc_width(W)-1:0]   cnt
);

  localparam int CW = pc_width(W);

  // Sum the set bits of vec.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) begin
      cnt = cnt + CW'(vec[i]);
    end
  end

endmodule

// File: rtl/adder_activity_monitor.sv
// Switching-activity monitor for the characterization adder. Counts bit
// toggles on input1, input2 and sum over a start/stop measurement window.
// Optional feature macro: ACTIVITY_PEAK_TRACK_EN adds peak_tog/peak_cyc,
// the largest per-cycle toggle total in the window and when it first hit.
//
// Handshake: start and stop are single-cycle pulses sampled on the rising
// edge of clk; the result is valid while done=1 and stays frozen until the
// next start (start beats stop when both arrive in IDLE or DONE).
module adder_activity_monitor
  import adder_activity_pkg::*;
#(
  parameter int N     = 7,
  parameter int CNT_W = 32,
  parameter int CYC_W = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          stop,
  input  logic [N-1:0]                  input1,
  input  logic [N-1:0]                  input2,
  input  logic [N-1:0]                  sum,
  output logic                          busy,
  output logic                          done,
  output logic [CYC_W-1:0]              cyc_cnt,
  output logic [CNT_W-1:0]              tog_in1,
  output logic [CNT_W-1:0]              tog_in2,
  output logic [CNT_W-1:0]              tog_sum,
  output logic [CNT_W+TOT_EXTRA_W-1:0]  tog_total,
  output logic                          ovf,
  output state_t                        dbg_state
`ifdef ACTIVITY_PEAK_TRACK_EN
  ,
  output logic [pc_width(3*N)-1:0]      peak_tog,
  output logic [CYC_W-1:0]              peak_cyc
`endif
);

  localparam int PC_W  = pc_width(N);
  localparam int PK_W  = pc_width(3 * N);
  localparam int TOT_W = CNT_W + TOT_EXTRA_W;
  localparam int CW1   = CNT_W + SAT_GUARD_W;
  localparam int TW1   = TOT_W + SAT_GUARD_W;
  localparam int YW1   = CYC_W + SAT_GUARD_W;

  state_t state, state_nx;
  logic   clear;

  logic [N-1:0]     prev1, prev2, prevs;
  logic [PC_W-1:0]  t1, t2, ts;
  logic [PK_W-1:0]  t_cyc;

  logic [CNT_W:0]   s1_full, s2_full, ss_full;
  logic [TOT_W:0]   tot_full;
  logic [CYC_W:0]   cyc_full;
  logic [CNT_W-1:0] s1_nx, s2_nx, ss_nx;
  logic [TOT_W-1:0] tot_nx;
  logic [CYC_W-1:0] cyc_nx;
  logic             any_sat;

  assign dbg_state = state;

  // Per-bus toggle counts against the previous sample.
  popcount #(.W(N)) u_pc_in1 (.vec(input1 ^ prev1), .cnt(t1));
  popcount #(.W(N)) u_pc_in2 (.vec(input2 ^ prev2), .cnt(t2));
  popcount #(.W(N)) u_pc_sum (.vec(sum    ^ prevs), .cnt(ts));

  assign t_cyc = PK_W'(t1) + PK_W'(t2) + PK_W'(ts);

  // Next-state logic; clear marks the edge that opens a new window.
  always_comb begin
    state_nx = state;
    clear    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_ARM;
          clear    = 1'b1;
        end
      end
      S_ARM:   state_nx = stop ? S_DONE : S_COUNT;
      S_COUNT: if (stop) state_nx = S_DONE;
      S_DONE: begin
        if (start) begin
          state_nx = S_ARM;
          clear    = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Saturating accumulation: the guard bit flags a result past all-ones.
  always_comb begin
    s1_full  = {1'b0, tog_in1}   + CW1'(t1);
    s2_full  = {1'b0, tog_in2}   + CW1'(t2);
    ss_full  = {1'b0, tog_sum}   + CW1'(ts);
    tot_full = {1'b0, tog_total} + TW1'(t_cyc);
    cyc_full = {1'b0, cyc_cnt}   + YW1'(1);
    s1_nx    = s1_full[CNT_W]  ? {CNT_W{1'b1}} : s1_full[CNT_W-1:0];
    s2_nx    = s2_full[CNT_W]  ? {CNT_W{1'b1}} : s2_full[CNT_W-1:0];
    ss_nx    = ss_full[CNT_W]  ? {CNT_W{1'b1}} : ss_full[CNT_W-1:0];
    tot_nx   = tot_full[TOT_W] ? {TOT_W{1'b1}} : tot_full[TOT_W-1:0];
    cyc_nx   = cyc_full[CYC_W] ? {CYC_W{1'b1}} : cyc_full[CYC_W-1:0];
    any_sat  = s1_full[CNT_W] | s2_full[CNT_W] | ss_full[CNT_W] |
               tot_full[TOT_W] | cyc_full[CYC_W];
  end

  // Registered status flags, counters and previous-sample registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      cyc_cnt   <= '0;
      tog_in1   <= '0;
      tog_in2   <= '0;
      tog_sum   <= '0;
      tog_total <= '0;
      ovf       <= 1'b0;
      prev1     <= '0;
      prev2     <= '0;
      prevs     <= '0;
    end else begin
      busy <= (state_nx == S_ARM) || (state_nx == S_COUNT);
      done <= (state_nx == S_DONE);
      if (clear) begin
        cyc_cnt   <= '0;
        tog_in1   <= '0;
        tog_in2   <= '0;
        tog_sum   <= '0;
        tog_total <= '0;
        ovf       <= 1'b0;
      end else if (state == S_COUNT) begin
        cyc_cnt   <= cyc_nx;
        tog_in1   <= s1_nx;
        tog_in2   <= s2_nx;
        tog_sum   <= ss_nx;
        tog_total <= tot_nx;
        ovf       <= ovf | any_sat;
      end
      if ((state == S_ARM) || (state == S_COUNT)) begin
        prev1 <= input1;
        prev2 <= input2;
        prevs <= sum;
      end
    end
  end

`ifdef ACTIVITY_PEAK_TRACK_EN
  // Peak per-cycle total; strict compare keeps the first occurrence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_tog <= '0;
      peak_cyc <= '0;
    end else if (clear) begin
      peak_tog <= '0;
      peak_cyc <= '0;
    end else if ((state == S_COUNT) && (t_cyc > peak_tog)) begin
      peak_tog <= t_cyc;
      peak_cyc <= cyc_nx;
    end
  end
`endif

endmodule

// File: tb/tb_adder_activity_monitor.sv
// Bench for adder_activity_monitor: two instances (32-bit and 4-bit
// counters) share stimulus; window results are predicted from the raw
// sample lists and checked when done rises.
module tb_adder_activity_monitor;
  import adder_activity_pkg::*;

  localparam int N   = 7;
  localparam int CW  = 32;
  localparam int CWS = 4;

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] t1;
    logic [31:0] t2;
    logic [31:0] ts;
    logic [33:0] tot;
    logic        ovf;
    logic [4:0]  pk;
    logic [31:0] pc;
  } res_t;

  logic clk, rst_n, start, stop;
  logic [N-1:0] input1, input2, sum;

  logic busy, done, ovf;
  logic [31:0] cyc_cnt, tog_in1, tog_in2, tog_sum;
  logic [33:0] tog_total;
  state_t st;

  logic s_busy, s_done, s_ovf;
  logic [31:0] s_cyc_cnt;
  logic [3:0]  s_tog_in1, s_tog_in2, s_tog_sum;
  logic [5:0]  s_tog_total;
  state_t s_st;

`ifdef ACTIVITY_PEAK_TRACK_EN
  logic [4:0]  pk, s_pk;
  logic [31:0] pc, s_pc;
`endif

  res_t exp_q[$];
  res_t exp_s_q[$];
  logic [N-1:0] wa[0:31];
  logic [N-1:0] wb[0:31];
  logic [N-1:0] ws[0:31];
  int n_checks = 0;
  int n_errors = 0;
  logic done_d = 1'b0;

  adder_activity_monitor #(.N(N), .CNT_W(CW), .CYC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .input1(input1), .input2(input2), .sum(sum),
    .busy(busy), .done(done), .cyc_cnt(cyc_cnt),
    .tog_in1(tog_in1), .tog_in2(tog_in2), .tog_sum(tog_sum),
    .tog_total(tog_total), .ovf(ovf), .dbg_state(st)
`ifdef ACTIVITY_PEAK_TRACK_EN
    , .peak_tog(pk), .peak_cyc(pc)
`endif
  );

  adder_activity_monitor #(.N(N), .CNT_W(CWS), .CYC_W(32)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .input1(input1), .input2(input2), .sum(sum),
    .busy(s_busy), .done(s_done), .cyc_cnt(s_cyc_cnt),
    .tog_in1(s_tog_in1), .tog_in2(s_tog_in2), .tog_sum(s_tog_sum),
    .tog_total(s_tog_total), .ovf(s_ovf), .dbg_state(s_st)
`ifdef ACTIVITY_PEAK_TRACK_EN
    , .peak_tog(s_pk), .peak_cyc(s_pc)
`endif
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: window totals from the sample list (index 0 = ARM sample).
  function automatic res_t model(input int n, input int cw);
    res_t r;
    longint a1 = 0, a2 = 0, a3 = 0, at = 0;
    longint mc, mt;
    int best = 0, best_i = 0, d1, d2, d3;
    mc = (longint'(1) << cw) - 1;
    mt = (longint'(1) << (cw + 2)) - 1;
    for (int i = 1; i <= n; i++) begin
      d1 = $countones(wa[i] ^ wa[i-1]);
      d2 = $countones(wb[i] ^ wb[i-1]);
      d3 = $countones(ws[i] ^ ws[i-1]);
      a1 += d1; a2 += d2; a3 += d3; at += d1 + d2 + d3;
      if (d1 + d2 + d3 > best) begin
        best = d1 + d2 + d3;
        best_i = i;
      end
    end
    r = '0;
    r.cyc = 32'(n);
    r.t1  = 32'((a1 > mc) ? mc : a1);
    r.t2  = 32'((a2 > mc) ? mc : a2);
    r.ts  = 32'((a3 > mc) ? mc : a3);
    r.tot = 34'((at > mt) ? mt : at);
    r.ovf = (a1 > mc) || (a2 > mc) || (a3 > mc) || (at > mt);
    r.pk  = 5'(best);
    r.pc  = 32'(best_i);
    return r;
  endfunction

  task automatic drive(input logic st_i, input logic sp_i,
                       input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] s);
    @(negedge clk);
    start = st_i; stop = sp_i; input1 = a; input2 = b; sum = s;
  endtask

  function automatic logic [N-1:0] rnd7();
    return N'($urandom_range(0, 127));
  endfunction

  task automatic fill_random(input int n);
    for (int i = 0; i <= n; i++) begin
      wa[i] = rnd7(); wb[i] = rnd7(); ws[i] = rnd7();
    end
  endtask

  // One window: start cycle, ARM sample, n COUNT samples (stop on the last).
  task automatic run_window(input int n, input bit collide, input bit mid_start);
    drive(1'b1, collide, rnd7(), rnd7(), rnd7());
    drive(1'b0, n == 0, wa[0], wb[0], ws[0]);
    for (int i = 1; i <= n; i++) begin
      drive(mid_start && (i == n / 2 + 1) && (i < n), i == n, wa[i], wb[i], ws[i]);
    end
    exp_q.push_back(model(n, CW));
    exp_s_q.push_back(model(n, CWS));
    repeat ($urandom_range(0, 2)) drive(1'b0, 1'(($urandom_range(0, 1))), rnd7(), rnd7(), rnd7());
  endtask

  // Monitor: compare a finished window whenever done rises.
  always @(negedge clk) begin
    res_t r, rs;
    if (!rst_n) begin
      done_d = 1'b0;
    end else begin
      if (done && !done_d) begin
        n_checks++;
        if (exp_q.size() == 0 || exp_s_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending window");
        end else begin
          r  = exp_q.pop_front();
          rs = exp_s_q.pop_front();
          check("busy_at_done", 64'(busy), 64'd0);
          check("cyc_cnt", 64'(cyc_cnt), 64'(r.cyc));
          check("tog_in1", 64'(tog_in1), 64'(r.t1));
          check("tog_in2", 64'(tog_in2), 64'(r.t2));
          check("tog_sum", 64'(tog_sum), 64'(r.ts));
          check("tog_total", 64'(tog_total), 64'(r.tot));
          check("ovf", 64'(ovf), 64'(r.ovf));
          check("s_done", 64'(s_done), 64'd1);
          check("s_cyc_cnt", 64'(s_cyc_cnt), 64'(rs.cyc));
          check("s_tog_in1", 64'(s_tog_in1), 64'(rs.t1));
          check("s_tog_in2", 64'(s_tog_in2), 64'(rs.t2));
          check("s_tog_sum", 64'(s_tog_sum), 64'(rs.ts));
          check("s_tog_total", 64'(s_tog_total), 64'(rs.tot));
          check("s_ovf", 64'(s_ovf), 64'(rs.ovf));
`ifdef ACTIVITY_PEAK_TRACK_EN
          check("peak_tog", 64'(pk), 64'(r.pk));
          check("peak_cyc", 64'(pc), 64'(r.pc));
          check("s_peak_tog", 64'(s_pk), 64'(rs.pk));
          check("s_peak_cyc", 64'(s_pc), 64'(rs.pc));
`endif
        end
      end
      done_d = done;
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_cyc"}, 64'(cyc_cnt), 64'd0);
    check({tag, "_tog_in1"}, 64'(tog_in1), 64'd0);
    check({tag, "_tog_in2"}, 64'(tog_in2), 64'd0);
    check({tag, "_tog_sum"}, 64'(tog_sum), 64'd0);
    check({tag, "_tog_total"}, 64'(tog_total), 64'd0);
    check({tag, "_ovf"}, 64'(ovf), 64'd0);
    check({tag, "_state"}, 64'(st), 64'(S_IDLE));
    check({tag, "_s_tog_total"}, 64'(s_tog_total), 64'd0);
`ifdef ACTIVITY_PEAK_TRACK_EN
    check({tag, "_peak_tog"}, 64'(pk), 64'd0);
    check({tag, "_peak_cyc"}, 64'(pc), 64'd0);
`endif
  endtask

  // Main stimulus sequence.
  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    input1 = '0; input2 = '0; sum = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Stop alone in IDLE is ignored.
    drive(1'b0, 1'b1, rnd7(), rnd7(), rnd7());
    drive(1'b0, 1'b0, rnd7(), rnd7(), rnd7());
    check("idle_stop_state", 64'(st), 64'(S_IDLE));
    check("idle_stop_done", 64'(done), 64'd0);
    check("idle_stop_busy", 64'(busy), 64'd0);

    // Constant buses for 10 COUNT cycles.
    for (int i = 0; i <= 10; i++) begin
      wa[i] = 7'h2A; wb[i] = 7'h15; ws[i] = 7'h3F;
    end
    run_window(10, 1'b0, 1'b0);

    // input1 alternating 0x00/0x7F for 8 cycles.
    for (int i = 0; i <= 8; i++) begin
      wa[i] = (i % 2 == 1) ? 7'h7F : 7'h00; wb[i] = '0; ws[i] = '0;
    end
    run_window(8, 1'b0, 1'b0);

    // Three alternating cycles: saturates the 4-bit instance.
    run_window(3, 1'b0, 1'b0);

    // Per-cycle totals 3, 9, 9, 4.
    wa[0] = 7'h00; wa[1] = 7'h07; wa[2] = 7'h78; wa[3] = 7'h07; wa[4] = 7'h00;
    wb[0] = 7'h00; wb[1] = 7'h00; wb[2] = 7'h03; wb[3] = 7'h00; wb[4] = 7'h00;
    ws[0] = 7'h00; ws[1] = 7'h00; ws[2] = 7'h00; ws[3] = 7'h00; ws[4] = 7'h01;
    run_window(4, 1'b0, 1'b0);

    // Stop in ARM, start+stop collision, start during COUNT.
    fill_random(0);
    run_window(0, 1'b0, 1'b0);
    fill_random(5);
    run_window(5, 1'b1, 1'b0);
    fill_random(6);
    run_window(6, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a window.
    drive(1'b1, 1'b0, rnd7(), rnd7(), rnd7());
    drive(1'b0, 1'b0, rnd7(), rnd7(), rnd7());
    check("arm_state", 64'(st), 64'(S_ARM));
    check("arm_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, rnd7(), rnd7(), rnd7());
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    fill_random(5);
    run_window(5, 1'b0, 1'b0);

    // Randomised windows.
    for (int k = 0; k < 20; k++) begin
      int n;
      n = $urandom_range(0, 12);
      fill_random(n);
      run_window(n, 1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))));
    end

    repeat (4) drive(1'b0, 1'b0, rnd7(), rnd7(), rnd7());
    check("pending_windows", 64'(exp_q.size()), 64'd0);
    check("pending_windows_s", 64'(exp_s_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
